// File: rtl/serializador_tx_pkg.sv
// rtl/serializador_tx_pkg.sv - shared phy line symbols and serializer state type
package serializador_tx_pkg;

   // Line symbols, also used by the deserializer and its symbol aligner
   localparam logic [7:0] COM = 8'hBC;
   localparam logic [7:0] IDL = 8'h7C;

   typedef enum logic {
      SYNC   = 1'b0,
      ACTIVE = 1'b1
   } tx_state_e;

endpackage

// File: rtl/serializador_tx_piso8.sv
// rtl/serializador_tx_piso8.sv - 8-bit parallel-load, shift-left register
module serializador_tx_piso8 (
   input  logic       clk_i,
   input  logic       resetn_i,
   input  logic       load_i,
   input  logic [7:0] par_i,
   output logic       ser_o
);

   logic [7:0] sr_q;
   logic [7:0] sr_d;

   // Load a new symbol or shift left filling with zero
   always_comb begin
      sr_d = {sr_q[6:0], 1'b0};
      if (load_i) begin
         sr_d = par_i;
      end
   end

   // Shift register storage, cleared in reset
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         sr_q <= 8'h00;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign ser_o = sr_q[7];

endmodule

// File: rtl/serializador_tx.sv
// rtl/serializador_tx.sv - byte-to-bit serializer with COM preamble and IDL fill
module serializador_tx
   import serializador_tx_pkg::*;
#(
   parameter int SYNC_COUNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       data_out,
   output logic       load,
   output logic       active
);

   localparam logic [7:0] LAST_SYNC = 8'(SYNC_COUNT - 1);

   logic [2:0] bit_cnt_q;
   logic [2:0] bit_cnt_d;
   logic [7:0] sym_cnt_q;
   logic [7:0] sym_cnt_d;
   tx_state_e  state_q;
   tx_state_e  state_d;
   logic [7:0] sym;
   logic       load_edge;

   // Bit slot 0 is the edge that samples the upstream byte
   assign load_edge = (bit_cnt_q == 3'd0);
   assign bit_cnt_d = bit_cnt_q + 3'd1;

   // Symbol choice and preamble progress, evaluated only on load edges
   always_comb begin
      state_d   = state_q;
      sym_cnt_d = sym_cnt_q;
      sym       = COM;
      if (load_edge) begin
         if (state_q == SYNC) begin
            sym       = COM;
            sym_cnt_d = sym_cnt_q + 8'd1;
            if (sym_cnt_q == LAST_SYNC) begin
               state_d = ACTIVE;
            end
         end else begin
            sym = valid_in ? data_in : IDL;
         end
      end
   end

   // Bit counter, preamble counter and FSM state
   always_ff @(posedge clk_32f) begin
      if (!reset) begin
         bit_cnt_q <= 3'd0;
         sym_cnt_q <= 8'd0;
         state_q   <= SYNC;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         sym_cnt_q <= sym_cnt_d;
         state_q   <= state_d;
      end
   end

   serializador_tx_piso8 u_piso8 (
      .clk_i    (clk_32f),
      .resetn_i (reset),
      .load_i   (load_edge),
      .par_i    (sym),
      .ser_o    (data_out)
   );

   assign load   = load_edge;
   assign active = (state_q == ACTIVE);

endmodule

// File: tb/tb_serializador_tx.sv
// tb/tb_serializador_tx.sv - directed self-checking bench for serializador_tx
module tb_serializador_tx;

   logic       clk_32f;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic       data_out;
   logic       load;
   logic       active;

   int errors = 0;
   int checks = 0;

   serializador_tx #(.SYNC_COUNT(4)) dut (
      .clk_32f  (clk_32f),
      .reset    (reset),
      .data_in  (data_in),
      .valid_in (valid_in),
      .data_out (data_out),
      .load     (load),
      .active   (active)
   );

   initial clk_32f = 1'b0;
   always #5 clk_32f = ~clk_32f;

   // Advance one bit clock and settle past the edge
   task automatic step();
      @(posedge clk_32f);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expect a whole symbol on the line; set up the next byte before the next load edge
   task automatic send(input string tag, input logic [7:0] sym, input logic exp_act,
                       input logic [7:0] nxt_data, input logic nxt_valid);
      for (int i = 0; i < 8; i++) begin
         step();
         chk({tag, "_bit"}, 8'(data_out), 8'(sym[7-i]));
         chk({tag, "_load"}, 8'(load), 8'(i == 7));
         chk({tag, "_active"}, 8'(active), 8'(exp_act));
      end
      data_in  = nxt_data;
      valid_in = nxt_valid;
   endtask

   initial begin
      reset    = 1'b0;
      valid_in = 1'b1;
      data_in  = 8'h55;

      // Reset held three cycles
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_data", 8'(data_out), 8'h00);
         chk("rst_active", 8'(active), 8'h00);
         chk("rst_load", 8'(load), 8'h01);
      end
      reset = 1'b1;

      // Preamble with a valid byte offered that must be dropped
      send("com0", 8'hBC, 1'b0, 8'h55, 1'b1);
      send("com1", 8'hBC, 1'b0, 8'h55, 1'b1);
      send("com2", 8'hBC, 1'b0, 8'h55, 1'b1);
      send("com3", 8'hBC, 1'b1, 8'hA5, 1'b1);

      // First data byte, then idle fill that ignores data_in
      send("a5", 8'hA5, 1'b1, 8'hFF, 1'b0);
      send("idl", 8'h7C, 1'b1, 8'h01, 1'b1);

      // Back-to-back bytes
      send("b01", 8'h01, 1'b1, 8'h80, 1'b1);
      send("b80", 8'h80, 1'b1, 8'h3C, 1'b1);
      send("b3c", 8'h3C, 1'b1, 8'hFF, 1'b1);

      // Reset in the middle of an 0xFF symbol, before bit 3 goes out
      for (int i = 0; i < 4; i++) begin
         step();
         chk("ff_bit", 8'(data_out), 8'h01);
      end
      reset    = 1'b0;
      data_in  = 8'h55;
      valid_in = 1'b1;
      step();
      chk("midrst_data", 8'(data_out), 8'h00);
      chk("midrst_active", 8'(active), 8'h00);
      chk("midrst_load", 8'(load), 8'h01);
      step();
      chk("midrst_hold", 8'(data_out), 8'h00);
      reset = 1'b1;

      // Full preamble again, then an idle symbol
      send("rcom0", 8'hBC, 1'b0, 8'h55, 1'b1);
      send("rcom1", 8'hBC, 1'b0, 8'h55, 1'b1);
      send("rcom2", 8'hBC, 1'b0, 8'h55, 1'b1);
      send("rcom3", 8'hBC, 1'b1, 8'h55, 1'b0);
      send("ridl", 8'h7C, 1'b1, 8'h00, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
